// File: rtl/pgm_rom_loader.sv
// rtl/pgm_rom_loader.sv - ioctl ROM-download consumer: address translation, word FIFO, SDRAM write requester.
module pgm_rom_loader #(
    parameter int                  FIFO_DEPTH = 4,
    parameter int                  SDRAM_AW   = 25,
    parameter logic [SDRAM_AW-1:0] BASE0      = 25'h0000000,
    parameter logic [SDRAM_AW-1:0] BASE1      = 25'h1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [26:0]         ioctl_addr,
    input  logic [15:0]         ioctl_dout,
    input  logic [7:0]          ioctl_index,
    output logic                ioctl_wait,
    output logic                sdr_req,
    output logic [SDRAM_AW-1:0] sdr_addr,
    output logic [15:0]         sdr_din,
    input  logic                sdr_ack,
    output logic                load_busy,
    output logic                load_done,
    output logic                overflow,
    output logic [23:0]         word_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = SDRAM_AW + 16;

    typedef enum logic { IDLE, REQ } state_t;

    state_t                state_q;
    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  dl_q, seen_dl_q;
    logic                  wait_q, req_q, overflow_q, done_q;
    logic [SDRAM_AW-1:0]   addr_q;
    logic [15:0]           din_q;
    logic [23:0]           wcnt_q;

    logic                  push, push_ok, pop, full, dl_rise;
    logic [SDRAM_AW-1:0]   base, sum;
    logic [EW-1:0]         push_entry, head, next_head;

    always_comb begin
        push       = ioctl_download && ioctl_wr && (ioctl_index == 8'd0 || ioctl_index == 8'd1);
        base       = ioctl_index[0] ? BASE1 : BASE0;
        sum        = base + ioctl_addr[SDRAM_AW-1:0];
        push_entry = {sum[SDRAM_AW-1:1], 1'b0, ioctl_dout};
        pop        = (state_q == REQ) && sdr_ack;
        full       = (count_q == CW'(FIFO_DEPTH));
        // Pop is applied first, so a full FIFO still accepts a word on an ack cycle.
        push_ok    = push && (!full || pop);
        count_d    = count_q + CW'(push_ok) - CW'(pop);
        dl_rise    = ioctl_download && !dl_q;
        head       = mem_q[rd_ptr_q];
        // With one word left, the follow-on entry can only be the one arriving this cycle.
        next_head  = (count_q > CW'(1)) ? mem_q[rd_ptr_q + PW'(1)] : push_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dl_q       <= 1'b0;
            seen_dl_q  <= 1'b0;
            wait_q     <= 1'b0;
            req_q      <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            wcnt_q     <= '0;
        end else begin
            dl_q    <= ioctl_download;
            count_q <= count_d;
            wait_q  <= (count_d >= CW'(FIFO_DEPTH - 1));

            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end

            if (ioctl_download) begin
                seen_dl_q <= 1'b1;
            end

            if (dl_rise) begin
                overflow_q <= 1'b0;
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end

            if (dl_rise) begin
                wcnt_q <= '0;
            end else if (pop && wcnt_q != 24'hFFFFFF) begin
                wcnt_q <= wcnt_q + 24'd1;
            end

            if (dl_rise) begin
                done_q <= 1'b0;
            end else if (!ioctl_download && count_q == '0 && state_q == IDLE && seen_dl_q) begin
                done_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= head[EW-1:16];
                        din_q   <= head[15:0];
                    end
                end
                REQ: begin
                    if (sdr_ack) begin
                        if (count_q > CW'(1) || push_ok) begin
                            addr_q <= next_head[EW-1:16];
                            din_q  <= next_head[15:0];
                        end else begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ioctl_wait = wait_q;
    assign sdr_req    = req_q;
    assign sdr_addr   = addr_q;
    assign sdr_din    = din_q;
    assign overflow   = overflow_q;
    assign load_done  = done_q;
    assign word_count = wcnt_q;
    assign load_busy  = ioctl_download || (count_q != '0) || req_q;
endmodule

// File: tb/tb_pgm_rom_loader.sv
// tb/tb_pgm_rom_loader.sv - directed self-checking bench for pgm_rom_loader.
module tb_pgm_rom_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download, ioctl_wr, sdr_ack;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait, sdr_req, load_busy, load_done, overflow;
    logic [24:0] sdr_addr;
    logic [15:0] sdr_din;
    logic [23:0] word_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pgm_rom_loader #(
        .FIFO_DEPTH(4), .SDRAM_AW(25), .BASE0(25'h0000010), .BASE1(25'h1000000)
    ) dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .ioctl_wait(ioctl_wait),
        .sdr_req(sdr_req), .sdr_addr(sdr_addr), .sdr_din(sdr_din), .sdr_ack(sdr_ack),
        .load_busy(load_busy), .load_done(load_done), .overflow(overflow),
        .word_count(word_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; sdr_ack = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sdr_ack = (i % 3 == 1);
            tick();
        end
        sdr_ack = 1'b0;
        checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", sdr_req); end
        checks++; if (sdr_addr !== 25'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", sdr_addr); end
        checks++; if (sdr_din !== 16'h0) begin errors++; $display("FAIL reset_din got %h exp 0", sdr_din); end
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait got %b exp 0", ioctl_wait); end
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", load_busy); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", load_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        checks++; if (word_count !== 24'd0) begin errors++; $display("FAIL reset_wcnt got %0d exp 0", word_count); end
    endtask

    task automatic test_single();
        ioctl_download = 1'b1;
        tick();
        ioctl_wr = 1'b1; ioctl_index = 8'd1; ioctl_addr = 27'h000010; ioctl_dout = 16'hBEEF; sdr_ack = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL single_req_early got %b exp 0", sdr_req); end
        tick();
        checks++; if (sdr_req !== 1'b1) begin errors++; $display("FAIL single_req got %b exp 1", sdr_req); end
        checks++; if (sdr_addr !== 25'h1000010) begin errors++; $display("FAIL single_addr got %h exp 1000010", sdr_addr); end
        checks++; if (sdr_din !== 16'hBEEF) begin errors++; $display("FAIL single_din got %h exp beef", sdr_din); end
        tick();
        sdr_ack = 1'b0;
        checks++; if (word_count !== 24'd1) begin errors++; $display("FAIL single_wcnt got %0d exp 1", word_count); end
        checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL single_req_drop got %b exp 0", sdr_req); end
        ioctl_download = 1'b0;
        tick();
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", load_busy); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL single_done got %b exp 1", load_done); end
    endtask

    task automatic test_back_to_back();
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        tick();
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL b2b_done_clear got %b exp 0", load_done); end
        for (int i = 0; i < 8; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 27'(2 * i); ioctl_dout = 16'hA000 + 16'(i);
            tick();
            if (i == 1) begin
                checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL b2b_wait2 got %b exp 0", ioctl_wait); end
            end
            if (i == 2) begin
                checks++; if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL b2b_wait3 got %b exp 1", ioctl_wait); end
            end
            if (i == 3) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf4 got %b exp 0", overflow); end
            end
            if (i == 4) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf5 got %b exp 1", overflow); end
            end
        end
        ioctl_wr = 1'b0;
        checks++; if (word_count !== 24'd0) begin errors++; $display("FAIL b2b_wcnt0 got %0d exp 0", word_count); end
        sdr_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (sdr_req !== 1'b1) begin errors++; $display("FAIL b2b_req%0d got %b exp 1", k, sdr_req); end
            checks++; if (sdr_addr !== 25'h10 + 25'(2 * k)) begin errors++; $display("FAIL b2b_addr%0d got %h exp %h", k, sdr_addr, 25'h10 + 25'(2 * k)); end
            checks++; if (sdr_din !== 16'hA000 + 16'(k)) begin errors++; $display("FAIL b2b_din%0d got %h exp %h", k, sdr_din, 16'hA000 + 16'(k)); end
            tick();
        end
        sdr_ack = 1'b0;
        checks++; if (word_count !== 24'd4) begin errors++; $display("FAIL b2b_wcnt got %0d exp 4", word_count); end
        checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL b2b_req_end got %b exp 0", sdr_req); end
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL b2b_wait_end got %b exp 0", ioctl_wait); end
        ioctl_download = 1'b0;
        tick(); tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf_sticky got %b exp 1", overflow); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b exp 1", load_done); end
    endtask

    task automatic test_wrap();
        ioctl_download = 1'b1;
        tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf_clear got %b exp 0", overflow); end
        ioctl_wr = 1'b1; ioctl_index = 8'd0; ioctl_addr = 27'h1FFFFFF; ioctl_dout = 16'h1234;
        tick();
        ioctl_wr = 1'b0;
        tick();
        checks++; if (sdr_addr !== 25'h000000E) begin errors++; $display("FAIL wrap_addr got %h exp 000000e", sdr_addr); end
        checks++; if (sdr_din !== 16'h1234) begin errors++; $display("FAIL wrap_din got %h exp 1234", sdr_din); end
        sdr_ack = 1'b1;
        tick();
        sdr_ack = 1'b0;
        checks++; if (word_count !== 24'd1) begin errors++; $display("FAIL wrap_wcnt got %0d exp 1", word_count); end
    endtask

    task automatic test_bad_index();
        ioctl_wr = 1'b1; ioctl_index = 8'h05; ioctl_addr = 27'h0; ioctl_dout = 16'hFFFF;
        tick();
        ioctl_wr = 1'b0;
        tick();
        checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL badidx_req got %b exp 0", sdr_req); end
        checks++; if (word_count !== 24'd1) begin errors++; $display("FAIL badidx_wcnt got %0d exp 1", word_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL badidx_ovf got %b exp 0", overflow); end
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL badidx_wait got %b exp 0", ioctl_wait); end
    endtask

    task automatic test_reset_mid();
        ioctl_index = 8'd1;
        for (int i = 0; i < 2; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 27'(4 * i); ioctl_dout = 16'h5500 + 16'(i);
            tick();
        end
        ioctl_wr = 1'b0;
        checks++; if (sdr_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_pre got %b exp 1", sdr_req); end
        ioctl_download = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL rstmid_req got %b exp 0", sdr_req); end
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", load_busy); end
        checks++; if (word_count !== 24'd0) begin errors++; $display("FAIL rstmid_wcnt got %0d exp 0", word_count); end
        sdr_ack = 1'b1;
        tick();
        sdr_ack = 1'b0;
        tick();
        checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL rstmid_req_after got %b exp 0", sdr_req); end
        checks++; if (word_count !== 24'd0) begin errors++; $display("FAIL rstmid_wcnt_after got %0d exp 0", word_count); end
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after got %b exp 0", load_busy); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", load_done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_bad_index();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
